// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming KxK sliding-window generator with on-chip line buffers
module conv_window_gen #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 5,
    parameter int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    parameter int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       pix_in,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic [K*K*DATA_W-1:0]   win_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [ROW_W-1:0]        win_row,
    output logic [COL_W-1:0]        win_col,
    output logic                    win_last
);

    localparam logic [ROW_W-1:0] ROW_K1   = ROW_W'(K - 1);
    localparam logic [COL_W-1:0] COL_K1   = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    // Position of the next pixel to be accepted
    logic [ROW_W-1:0] in_row_q, in_row_d;
    logic [COL_W-1:0] in_col_q, in_col_d;

    // Registered window-side outputs
    logic             win_valid_q, win_valid_d;
    logic             win_last_q,  win_last_d;
    logic [ROW_W-1:0] win_row_q,   win_row_d;
    logic [COL_W-1:0] win_col_q,   win_col_d;

    // Line buffers: lb_q[r] holds image row (current_row - K + 1 + r);
    // lb_q[K-2] is always the row directly above the incoming pixel.
    logic [DATA_W-1:0] lb_q [K-1][IMG_W];

    // Window shift register, win_q[r][c] = element (r,c); column K-1 is newest
    logic [DATA_W-1:0] win_q [K][K];

    // Right-hand column entering the window on each accept
    logic [DATA_W-1:0] new_col [K];

    logic accept;
    logic emit;
    logic row_full;
    logic col_full;

    // The consumer only blocks input while an unconsumed window is pending
    assign pix_ready = !win_valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;

    // A full window exists once K rows and K columns of the frame have arrived;
    // the row gate also keeps stale previous-frame line-buffer data out of windows.
    assign row_full  = (in_row_q >= ROW_K1);
    assign col_full  = (in_col_q >= COL_K1);
    assign emit      = accept && row_full && col_full;

    // Build the incoming column from the line buffers plus the live pixel
    always_comb begin
        for (int r = 0; r < K; r++) begin
            new_col[r] = '0;
        end
        for (int r = 0; r < K - 1; r++) begin
            new_col[r] = lb_q[r][in_col_q];
        end
        new_col[K-1] = pix_in;
    end

    // Raster position counters: column wraps into the next row, row wraps into the next frame
    always_comb begin
        in_row_d = in_row_q;
        in_col_d = in_col_q;
        if (accept) begin
            if (in_col_q == COL_LAST) begin
                in_col_d = '0;
                if (in_row_q == ROW_LAST) begin
                    in_row_d = '0;
                end else begin
                    in_row_d = in_row_q + ROW_W'(1);
                end
            end else begin
                in_col_d = in_col_q + COL_W'(1);
            end
        end
    end

    // Output handshake: a new window replaces the old one, a bare take clears valid
    always_comb begin
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        if (emit) begin
            win_valid_d = 1'b1;
            win_row_d   = in_row_q - ROW_K1;
            win_col_d   = in_col_q - COL_K1;
            win_last_d  = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // Control registers with synchronous reset; a reset drops any partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            in_row_q    <= '0;
            in_col_q    <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            in_row_q    <= in_row_d;
            in_col_q    <= in_col_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    // Line buffers shift up one row at the accepted column; contents survive reset
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K - 2; r++) begin
                lb_q[r][in_col_q] <= lb_q[r+1][in_col_q];
            end
            lb_q[K-2][in_col_q] <= pix_in;
        end
    end

    // Window shifts left one column per accepted pixel, new column enters on the right
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][K-1] <= new_col[r];
            end
        end
    end

    // Flatten the window: element e = r*K + c occupies bits [e*DATA_W +: DATA_W]
    genvar gr, gc;
    generate
        for (gr = 0; gr < K; gr++) begin : g_row
            for (gc = 0; gc < K; gc++) begin : g_col
                assign win_data[(gr*K + gc)*DATA_W +: DATA_W] = win_q[gr][gc];
            end
        end
    endgenerate

    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign win_last  = win_last_q;

endmodule
